branch_issue_sched: RTL and testbench
=====================================

BRANCH_ISSUE_SCHED -- requirements
Module: branch_issue_sched

Interface
REQ-001 SHALL have ports, in order (defaults: DATA_W=32, TAG_W=4, OP_W=5, N=4):
 clk  in  1  clock, all state on rising edge
 rst  in  1  reset, asynchronous, active-high
 rdy  in  1  global enable; 0 = freeze all state and outputs
 flush  in  1  branch mispredict, discard all entries
 allocEn  in  1  dispatcher writes one branch entry
 allocOpO / allocOpT  in  DATA_W  operand values
 allocTagO / allocTagT  in  TAG_W  producer tags; TAG_FREE = value present
 allocOp  in  OP_W  branch opcode
 allocImm  in  DATA_W  offset
 allocPC  in  DATA_W  instruction address
 aluEn / aluTag / aluData  in  1 / TAG_W / DATA_W  ALU result broadcast
 lsEn / lsTag / lsData  in  1 / TAG_W / DATA_W  load/store result broadcast
 full  out  1  all N entries valid
 count  out  3  number of valid entries
 issueEn  out  1  issue bundle valid for branch execute unit
 issueOpO / issueOpT / issueImm / issuePC  out  DATA_W  issued fields
 issueOp  out  OP_W  issued opcode (NOP when issueEn=0)

Function
REQ-002 SHALL hold N entries: valid, tagO, tagT, dataO, dataT, op, imm, pc.
REQ-003 SHALL write allocation into the lowest-index invalid entry; allocEn while full=1 SHALL be ignored (dispatcher protocol violation; no state change).
REQ-004 SHALL compute full/count from registered valid bits only; a slot freed by issue in cycle t becomes allocatable in cycle t+1.
REQ-005 Wakeup: per entry operand, if tag!=TAG_FREE and (aluEn and aluTag==tag), capture aluData and set tag TAG_FREE; else the same test on the LS port; ALU SHALL take priority when both match.
REQ-006 Allocation bypass: an allocated operand whose tag matches a same-cycle broadcast SHALL be stored as data with TAG_FREE.
REQ-007 Entry ready = valid and both operand tags TAG_FREE after same-cycle wakeup (combinational next-state tags).
REQ-008 SHALL keep an NxN age matrix; on allocation the new entry's row is set to the current valid vector (new entry younger than all valid entries); rows and columns of freed entries are ignored.
REQ-009 Each cycle SHALL select the oldest ready entry (no other ready entry older); at most one issue per cycle.
REQ-010 Issue is registered: on the edge after an entry is selected, issueEn=1, issue fields = that entry's values with same-cycle wakeup data, entry valid cleared; with no selection issueEn=0, data outputs 0, issueOp=NOP.
REQ-011 Latency: allocation with both operands free at edge t -> issueEn=1 after edge t+1.
REQ-012 flush=1 SHALL clear all valid bits and force issueEn=0 at the next edge; concurrent allocEn is discarded.
REQ-013 rdy=0 SHALL hold all registers including issue outputs; broadcasts in that cycle are lost (upstream guarantees no broadcast while rdy=0).

Reset
REQ-014 rst SHALL asynchronously clear all valid bits, the age matrix and count; set tags TAG_FREE, data/imm/pc 0, op NOP; set issueEn=0, issue data 0, issueOp NOP, full=0.

Structure
REQ-015 TAG_FREE, NOP, DATA_W, TAG_W, OP_W SHALL come from the shared defines package, not be redefined locally.
REQ-016 Per-entry wakeup/next-state logic SHALL be one sub-module, brs_entry, instantiated N times; allocation, age matrix and select stay in the top.

Verification
REQ-017 Alloc PC=0x100, tags free, op=BEQ, opO=opT=5 -> issueEn=1 after the second edge, issuePC=0x100, issueOpO=5.
REQ-018 Alloc A (tagO=3), then B (free); ALU broadcasts tag 3 data 7 while B ready -> B issues first, A issues next cycle with issueOpO=7.
REQ-019 Same-cycle aluEn tag 2 data 9 and lsEn tag 2 data 4 on waiting entry -> captured operand=9.
REQ-020 Allocate 4 entries all waiting -> full=1, count=4; fifth allocEn ignored; broadcast wakes all -> issue in allocation order over 4 cycles, count returns to 0.
REQ-021 3 valid entries, flush with allocEn asserted -> next cycle count=0, issueEn=0, no later issue of any entry.
REQ-022 rst asserted mid-issue (issueEn=1) -> issueEn=0, full=0 immediately, without a clock edge.

Source files
------------

// File: rtl/branch_issue_sched_pkg.sv
// Shared widths, tag/opcode encodings and the operand wakeup helper
// used by the branch reservation station.
package branch_issue_sched_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int OP_W   = 5;

    localparam logic [TAG_W-1:0] TAG_FREE = '0;

    localparam logic [OP_W-1:0] NOP = 5'd0;
    localparam logic [OP_W-1:0] BEQ = 5'd1;
    localparam logic [OP_W-1:0] BNE = 5'd2;
    localparam logic [OP_W-1:0] BLT = 5'd3;
    localparam logic [OP_W-1:0] BGE = 5'd4;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } opnd_t;

    // ALU broadcast wins over load/store when both carry the awaited tag
    function automatic opnd_t wake(
        input opnd_t             o,
        input logic              alu_en,
        input logic [TAG_W-1:0]  alu_tag,
        input logic [DATA_W-1:0] alu_data,
        input logic              ls_en,
        input logic [TAG_W-1:0]  ls_tag,
        input logic [DATA_W-1:0] ls_data
    );
        opnd_t r;
        r = o;
        if (o.tag != TAG_FREE) begin
            if (alu_en && alu_tag == o.tag) begin
                r.tag  = TAG_FREE;
                r.data = alu_data;
            end else if (ls_en && ls_tag == o.tag) begin
                r.tag  = TAG_FREE;
                r.data = ls_data;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_issue_sched_entry.sv
// One reservation-station slot: operand storage, wakeup and readiness.
module brs_entry
    import branch_issue_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              alloc,
    input  logic              clr,
    input  opnd_t             alloc_src0,
    input  opnd_t             alloc_src1,
    input  logic [OP_W-1:0]   alloc_op,
    input  logic [DATA_W-1:0] alloc_imm,
    input  logic [DATA_W-1:0] alloc_pc,
    input  logic              aluEn,
    input  logic [TAG_W-1:0]  aluTag,
    input  logic [DATA_W-1:0] aluData,
    input  logic              lsEn,
    input  logic [TAG_W-1:0]  lsTag,
    input  logic [DATA_W-1:0] lsData,
    output logic              valid,
    output logic              ready,
    output logic [DATA_W-1:0] src0_data,
    output logic [DATA_W-1:0] src1_data,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] pc
);

    opnd_t src0_q, src1_q;
    opnd_t src0_w, src1_w;
    opnd_t new0_w, new1_w;

    assign src0_w = wake(src0_q, aluEn, aluTag, aluData,
                         lsEn, lsTag, lsData);
    assign src1_w = wake(src1_q, aluEn, aluTag, aluData,
                         lsEn, lsTag, lsData);
    assign new0_w = wake(alloc_src0, aluEn, aluTag, aluData,
                         lsEn, lsTag, lsData);
    assign new1_w = wake(alloc_src1, aluEn, aluTag, aluData,
                         lsEn, lsTag, lsData);

    assign ready = valid
                && src0_w.tag == TAG_FREE
                && src1_w.tag == TAG_FREE;
    assign src0_data = src0_w.data;
    assign src1_data = src1_w.data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid       <= 1'b0;
            src0_q.tag  <= TAG_FREE;
            src0_q.data <= '0;
            src1_q.tag  <= TAG_FREE;
            src1_q.data <= '0;
            op          <= NOP;
            imm         <= '0;
            pc          <= '0;
        end else if (rdy) begin
            if (flush) begin
                valid <= 1'b0;
            end else if (alloc) begin
                valid  <= 1'b1;
                src0_q <= new0_w;
                src1_q <= new1_w;
                op     <= alloc_op;
                imm    <= alloc_imm;
                pc     <= alloc_pc;
            end else begin
                src0_q <= src0_w;
                src1_q <= src1_w;
                if (clr)
                    valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/branch_issue_sched.sv
// Branch reservation station: N slots, age-ordered oldest-ready select,
// one registered issue per cycle toward the branch execute unit.
module branch_issue_sched
    import branch_issue_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              allocEn,
    input  logic [DATA_W-1:0] allocOpO,
    input  logic [DATA_W-1:0] allocOpT,
    input  logic [TAG_W-1:0]  allocTagO,
    input  logic [TAG_W-1:0]  allocTagT,
    input  logic [OP_W-1:0]   allocOp,
    input  logic [DATA_W-1:0] allocImm,
    input  logic [DATA_W-1:0] allocPC,
    input  logic              aluEn,
    input  logic [TAG_W-1:0]  aluTag,
    input  logic [DATA_W-1:0] aluData,
    input  logic              lsEn,
    input  logic [TAG_W-1:0]  lsTag,
    input  logic [DATA_W-1:0] lsData,
    output logic              full,
    output logic [2:0]        count,
    output logic              issueEn,
    output logic [DATA_W-1:0] issueOpO,
    output logic [DATA_W-1:0] issueOpT,
    output logic [DATA_W-1:0] issueImm,
    output logic [DATA_W-1:0] issuePC,
    output logic [OP_W-1:0]   issueOp
);

    logic [N-1:0]      valid, ready, sel, slot;
    logic [DATA_W-1:0] d0 [N];
    logic [DATA_W-1:0] d1 [N];
    logic [DATA_W-1:0] imm [N];
    logic [DATA_W-1:0] pc [N];
    logic [OP_W-1:0]   op [N];
    // age[i][j] set: entry j is older than entry i
    logic [N-1:0]      age [N];
    logic              do_alloc;
    opnd_t             new0, new1;

    logic [DATA_W-1:0] nxt_o, nxt_t, nxt_imm, nxt_pc;
    logic [OP_W-1:0]   nxt_op;

    assign full     = &valid;
    assign do_alloc = allocEn && !full && !flush;
    assign new0     = '{tag: allocTagO, data: allocOpO};
    assign new1     = '{tag: allocTagT, data: allocOpT};

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++)
            count = count + 3'(valid[i]);
    end

    always_comb begin
        slot = '0;
        for (int i = 0; i < N; i++)
            if (!valid[i] && slot == '0)
                slot[i] = do_alloc;
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            sel[i] = ready[i];
            for (int j = 0; j < N; j++)
                if (j != i && ready[j] && age[i][j])
                    sel[i] = 1'b0;
        end
    end

    always_comb begin
        nxt_o   = '0;
        nxt_t   = '0;
        nxt_imm = '0;
        nxt_pc  = '0;
        nxt_op  = NOP;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                nxt_o   = d0[i];
                nxt_t   = d1[i];
                nxt_imm = imm[i];
                nxt_pc  = pc[i];
                nxt_op  = op[i];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_ent
        brs_entry u_ent (
            .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
            .alloc(slot[g]), .clr(sel[g]),
            .alloc_src0(new0), .alloc_src1(new1),
            .alloc_op(allocOp), .alloc_imm(allocImm),
            .alloc_pc(allocPC),
            .aluEn(aluEn), .aluTag(aluTag), .aluData(aluData),
            .lsEn(lsEn), .lsTag(lsTag), .lsData(lsData),
            .valid(valid[g]), .ready(ready[g]),
            .src0_data(d0[g]), .src1_data(d1[g]),
            .op(op[g]), .imm(imm[g]), .pc(pc[g])
        );
    end

    // a newly written row records every current entry as older;
    // its column is cleared so stale rows never outrank it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                age[i] <= '0;
        end else if (rdy && do_alloc) begin
            for (int i = 0; i < N; i++)
                age[i] <= slot[i] ? valid : (age[i] & ~slot);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issueEn  <= 1'b0;
            issueOpO <= '0;
            issueOpT <= '0;
            issueImm <= '0;
            issuePC  <= '0;
            issueOp  <= NOP;
        end else if (rdy) begin
            issueEn  <= !flush && |sel;
            issueOpO <= flush ? '0 : nxt_o;
            issueOpT <= flush ? '0 : nxt_t;
            issueImm <= flush ? '0 : nxt_imm;
            issuePC  <= flush ? '0 : nxt_pc;
            issueOp  <= flush ? NOP : nxt_op;
        end
    end

endmodule

// File: tb/tb_branch_issue_sched.sv
// Directed self-checking bench for branch_issue_sched.
module tb_branch_issue_sched;
    import branch_issue_sched_pkg::*;

    logic              clk = 1'b0;
    logic              rst, rdy, flush, allocEn;
    logic [DATA_W-1:0] allocOpO, allocOpT, allocImm, allocPC;
    logic [TAG_W-1:0]  allocTagO, allocTagT;
    logic [OP_W-1:0]   allocOp;
    logic              aluEn, lsEn;
    logic [TAG_W-1:0]  aluTag, lsTag;
    logic [DATA_W-1:0] aluData, lsData;
    logic              full, issueEn;
    logic [2:0]        count;
    logic [DATA_W-1:0] issueOpO, issueOpT, issueImm, issuePC;
    logic [OP_W-1:0]   issueOp;

    int checks = 0;
    int errors = 0;

    branch_issue_sched dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .allocEn(allocEn),
        .allocOpO(allocOpO), .allocOpT(allocOpT),
        .allocTagO(allocTagO), .allocTagT(allocTagT),
        .allocOp(allocOp), .allocImm(allocImm), .allocPC(allocPC),
        .aluEn(aluEn), .aluTag(aluTag), .aluData(aluData),
        .lsEn(lsEn), .lsTag(lsTag), .lsData(lsData),
        .full(full), .count(count), .issueEn(issueEn),
        .issueOpO(issueOpO), .issueOpT(issueOpT),
        .issueImm(issueImm), .issuePC(issuePC), .issueOp(issueOp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        allocEn = 1'b0;
        aluEn   = 1'b0;
        lsEn    = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic put(input logic [31:0] p, input logic [3:0] t0,
                       input logic [3:0] t1, input logic [31:0] o0,
                       input logic [31:0] o1);
        allocEn   = 1'b1;
        allocPC   = p;
        allocTagO = t0;
        allocTagT = t1;
        allocOpO  = o0;
        allocOpT  = o1;
        allocImm  = p + 32'h8;
        allocOp   = BEQ;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        quiet();
        put(32'h0, TAG_FREE, TAG_FREE, 0, 0);
        allocEn = 1'b0;
        aluTag = '0; aluData = '0; lsTag = '0; lsData = '0;
        #12;
        chk("rst_issueEn", issueEn, 0);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_issueOp", issueOp, NOP);
        chk("rst_issuePC", issuePC, 0);
        rst = 1'b0;

        // single ready branch, two-edge latency
        put(32'h100, TAG_FREE, TAG_FREE, 5, 5);
        tick();
        allocEn = 1'b0;
        chk("lat_e1_issueEn", issueEn, 0);
        chk("lat_e1_count", count, 1);
        tick();
        chk("lat_issueEn", issueEn, 1);
        chk("lat_issuePC", issuePC, 32'h100);
        chk("lat_issueOpO", issueOpO, 5);
        chk("lat_issueOp", issueOp, BEQ);
        chk("lat_issueImm", issueImm, 32'h108);
        chk("lat_count", count, 0);
        tick();
        chk("lat_idle_issueEn", issueEn, 0);
        chk("lat_idle_issueOp", issueOp, NOP);

        // younger ready entry bypasses older waiting one
        put(32'h200, 4'd3, TAG_FREE, 32'hdead, 1);
        tick();
        put(32'h300, TAG_FREE, TAG_FREE, 11, 12);
        tick();
        allocEn = 1'b0;
        tick();
        chk("ooo_B_issueEn", issueEn, 1);
        chk("ooo_B_pc", issuePC, 32'h300);
        aluEn = 1'b1; aluTag = 4'd3; aluData = 32'd7;
        tick();
        aluEn = 1'b0;
        chk("ooo_A_issueEn", issueEn, 1);
        chk("ooo_A_pc", issuePC, 32'h200);
        chk("ooo_A_opO", issueOpO, 7);
        tick();
        chk("ooo_done_issueEn", issueEn, 0);
        chk("ooo_done_count", count, 0);

        // ALU beats LS on the same tag
        put(32'h400, 4'd2, TAG_FREE, 32'hdead, 3);
        tick();
        allocEn = 1'b0;
        aluEn = 1'b1; aluTag = 4'd2; aluData = 32'd9;
        lsEn  = 1'b1; lsTag  = 4'd2; lsData  = 32'd4;
        tick();
        quiet();
        chk("prio_issueEn", issueEn, 1);
        chk("prio_opO", issueOpO, 9);

        // allocation bypass from the LS port
        put(32'h480, TAG_FREE, 4'd6, 2, 32'hbeef);
        lsEn = 1'b1; lsTag = 4'd6; lsData = 32'h44;
        tick();
        quiet();
        chk("byp_count", count, 1);
        tick();
        chk("byp_issueEn", issueEn, 1);
        chk("byp_opT", issueOpT, 32'h44);
        tick();

        // fill, overflow, wake all, drain in order (with a stall)
        for (int k = 0; k < 4; k++) begin
            put(32'h500 + 32'(k) * 32'h10, 4'd5, TAG_FREE, 0, k);
            tick();
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 4);
        put(32'h540, TAG_FREE, TAG_FREE, 0, 0);
        tick();
        allocEn = 1'b0;
        chk("ovf_count", count, 4);
        chk("ovf_issueEn", issueEn, 0);
        aluEn = 1'b1; aluTag = 4'd5; aluData = 32'h55;
        tick();
        aluEn = 1'b0;
        chk("drain0_pc", issuePC, 32'h500);
        chk("drain0_opO", issueOpO, 32'h55);
        rdy = 1'b0;
        tick();
        chk("stall_pc", issuePC, 32'h500);
        chk("stall_issueEn", issueEn, 1);
        chk("stall_count", count, 3);
        rdy = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("drain_issueEn", issueEn, 1);
            chk("drain_pc", issuePC, 32'h500 + 32'(k) * 32'h10);
        end
        tick();
        chk("drain_end_issueEn", issueEn, 0);
        chk("drain_end_count", count, 0);

        // flush discards entries and concurrent allocation
        for (int k = 0; k < 3; k++) begin
            put(32'h600 + 32'(k) * 32'h10, 4'd7, TAG_FREE, 0, 0);
            tick();
        end
        chk("pre_flush_count", count, 3);
        put(32'h700, TAG_FREE, TAG_FREE, 1, 1);
        flush = 1'b1;
        tick();
        quiet();
        chk("flush_count", count, 0);
        chk("flush_issueEn", issueEn, 0);
        aluEn = 1'b1; aluTag = 4'd7; aluData = 32'h77;
        tick();
        aluEn = 1'b0;
        chk("flush_late1_issueEn", issueEn, 0);
        tick();
        chk("flush_late2_issueEn", issueEn, 0);
        chk("flush_late_count", count, 0);

        // asynchronous reset while an issue is on the outputs
        put(32'h800, TAG_FREE, TAG_FREE, 1, 1);
        tick();
        put(32'h810, 4'd8, TAG_FREE, 0, 0);
        tick();
        allocEn = 1'b0;
        chk("prerst_issueEn", issueEn, 1);
        chk("prerst_count", count, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_issueEn", issueEn, 0);
        chk("arst_full", full, 0);
        chk("arst_count", count, 0);
        chk("arst_issuePC", issuePC, 0);
        chk("arst_issueOp", issueOp, NOP);
        #1 rst = 1'b0;
        aluEn = 1'b1; aluTag = 4'd8; aluData = 32'h88;
        tick();
        aluEn = 1'b0;
        tick();
        chk("postrst_issueEn", issueEn, 0);
        chk("postrst_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
